// File: rtl/uart_tx_baud_if.sv
// Byte-level transmit handshake between a controller (master) and the
// UART transmitter (slave).
//   tx_en      request, level-sensitive, held by the controller
//   tx_data    byte to send (low nbits used)
//   nbits      data bits per frame, clamped to 5..8 by the transmitter
//   tx_done    frame complete, held until tx_en is seen low
//   parity_odd odd-parity select, present only with UART_TX_PARITY_EN
interface uart_tx_baud_if;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [3:0] nbits;
  logic       tx_done;
`ifdef UART_TX_PARITY_EN
  logic       parity_odd;

  modport master (output tx_en, output tx_data, output nbits, output parity_odd,
                  input tx_done);
  modport slave  (input tx_en, input tx_data, input nbits, input parity_odd,
                  output tx_done);
`else
  modport master (output tx_en, output tx_data, output nbits, input tx_done);
  modport slave  (input tx_en, input tx_data, input nbits, output tx_done);
`endif
endinterface

// File: rtl/uart_tx_baud.sv
// UART transmitter with a programmable oversampling baud tick generator.
// Frames are start(0), nbits data bits LSB first, [parity], stop(1); each
// serial bit lasts OVS ticks. Optional parity bit enabled by defining the
// macro UART_TX_PARITY_EN.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   baud_div    tick period minus one, in clk cycles
//   tick        one-clk pulse every baud_div+1 cycles
//   tx          serial line, idle high
//   bus         handshake (tx_en/tx_data/nbits/tx_done[/parity_odd])
module uart_tx_baud #(
  parameter int DIV_W = 16,
  parameter int OVS   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick,
  output logic             tx,
  uart_tx_baud_if.slave    bus
);

  localparam int TCW = $clog2(OVS);
  localparam logic [TCW-1:0]   TC_LAST = TCW'(OVS - 1);
  localparam logic [TCW-1:0]   TC_ONE  = 1;
  localparam logic [DIV_W-1:0] CNT_ONE = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;
`endif

  // Index of the last data bit for a requested width, clamped to 5..8 bits.
  function automatic logic [2:0] last_idx(input logic [3:0] n);
    if (n < 4'd5)      return 3'd4;
    else if (n > 4'd8) return 3'd7;
    else               return n[2:0] - 3'd1;
  endfunction

  function automatic logic [7:0] data_mask(input logic [2:0] last);
    return 8'hFF >> (3'd7 - last);
  endfunction

  logic [DIV_W-1:0] div_cnt;
  state_t           state, state_n;
  logic [TCW-1:0]   tcnt, tcnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [2:0]       last_q, last_n;
  logic [7:0]       data_q, data_n;
  logic             par_q, par_n;
  logic             done_q, done_n;
  logic             tx_n;
  logic             bit_end;

  // Free-running divider; a new baud_div is simply used at the next compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == baud_div) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + CNT_ONE;
      tick    <= 1'b0;
    end
  end

  assign bit_end = tick && (tcnt == TC_LAST);

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bit_n   = bit_idx;
    last_n  = last_q;
    data_n  = data_q;
    par_n   = par_q;
    done_n  = done_q;
    tx_n    = 1'b1;

    case (state)
      S_IDLE: begin
        if (bus.tx_en && !done_q) begin
          last_n  = last_idx(bus.nbits);
          data_n  = bus.tx_data & data_mask(last_idx(bus.nbits));
`ifdef UART_TX_PARITY_EN
          par_n   = ^(bus.tx_data & data_mask(last_idx(bus.nbits))) ^ bus.parity_odd;
`endif
          tcnt_n  = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick) tcnt_n = bit_end ? '0 : tcnt + TC_ONE;
        if (bit_end) begin
          bit_n   = 3'd0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) tcnt_n = bit_end ? '0 : tcnt + TC_ONE;
        if (bit_end) begin
          if (bit_idx == last_q) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) tcnt_n = bit_end ? '0 : tcnt + TC_ONE;
        if (bit_end) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) tcnt_n = bit_end ? '0 : tcnt + TC_ONE;
        if (bit_end) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
      end
      S_DONE: begin
        // Holding tx_en parks here; a low sample releases the handshake.
        if (!bus.tx_en) begin
          done_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Line level is registered from the state being entered.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = data_n[bit_n];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_n = par_n;
`endif
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tcnt    <= '0;
      bit_idx <= '0;
      done_q  <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      tcnt    <= tcnt_n;
      bit_idx <= bit_n;
      done_q  <= done_n;
      tx      <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    last_q <= last_n;
    data_q <= data_n;
    par_q  <= par_n;
  end

  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_baud.sv
module tb_uart_tx_baud;
  localparam int DIV_W = 16;
  localparam int OVS   = 16;
  localparam int MAXC  = 2048;

  logic             clk = 1'b0;
  logic             reset;
  logic [DIV_W-1:0] baud_div;
  logic             tick;
  logic             tx;

  uart_tx_baud_if bus();

  uart_tx_baud #(.DIV_W(DIV_W), .OVS(OVS)) dut (
    .clk      (clk),
    .reset    (reset),
    .baud_div (baud_div),
    .tick     (tick),
    .tx       (tx),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic samp [0:MAXC-1];

  task automatic set_baud(input int bd);
    @(negedge clk);
    baud_div = DIV_W'(bd);
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    baud_div    = 16'd3;
    bus.tx_en   = 1'b0;
    bus.tx_data = 8'h00;
    bus.nbits   = 4'd8;
`ifdef UART_TX_PARITY_EN
    bus.parity_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++; if (tick !== 1'b0)        begin n_bad++; $display("FAIL reset_tick: got %b want 0", tick); end
    n_cmp++; if (tx !== 1'b1)          begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (bus.tx_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.tx_done); end
    reset = 1'b0;
  endtask

  // Any window of 8 periods must hold exactly 8 ticks, each period apart.
  task automatic test_tick(input int bd);
    int cnt, last, bad_gap;
    set_baud(bd);
    cnt = 0; last = -1; bad_gap = -1;
    for (int c = 0; c < 8 * (bd + 1); c++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        if (last >= 0 && (c - last) != bd + 1 && bad_gap < 0) bad_gap = c - last;
        last = c;
        cnt++;
      end
    end
    n_cmp++; if (cnt != 8)    begin n_bad++; $display("FAIL tick_count bd=%0d: got %0d want 8", bd, cnt); end
    n_cmp++; if (bad_gap >= 0) begin n_bad++; $display("FAIL tick_period bd=%0d: got gap %0d want %0d", bd, bad_gap, bd + 1); end
  endtask

  // Sends one frame and checks it against the frame rules: start bit up to
  // baud_div clks short, every later bit exactly OVS*(baud_div+1) clks,
  // the stop bit ending on the edge where tx_done rises.
  task automatic run_frame(input logic [7:0] data, input logic [3:0] nb,
                           input logic par_odd, input bit early_release,
                           input string name);
    int   nd, nbit, p, bd, c_done, c_start, lo, s, e;
    bit   exp_bits[$];
    logic par, ok, got;
    nd = (nb < 5) ? 5 : (nb > 8) ? 8 : int'(nb);
    bd = int'(baud_div);
    p  = OVS * (bd + 1);
    exp_bits = {};
    exp_bits.push_back(1'b0);
    par = par_odd;
    for (int i = 0; i < nd; i++) begin
      exp_bits.push_back(data[i]);
      par = par ^ data[i];
    end
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(par);
`endif
    exp_bits.push_back(1'b1);
    nbit = exp_bits.size();

    bus.tx_data = data;
    bus.nbits   = nb;
`ifdef UART_TX_PARITY_EN
    bus.parity_odd = par_odd;
`endif
    bus.tx_en = 1'b1;
    c_done = -1;
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      samp[c] = tx;
      if (early_release && c == 2) bus.tx_en = 1'b0;
      if (bus.tx_done === 1'b1) begin c_done = c; break; end
    end
    n_cmp++;
    if (c_done < 0) begin
      n_bad++;
      $display("FAIL %s_timeout: tx_done not seen in %0d clks (par=%0b)", name, MAXC, par);
      bus.tx_en = 1'b0;
      return;
    end

    c_start = -1;
    for (int c = 0; c < c_done; c++) if (samp[c] === 1'b0) begin c_start = c; break; end
    lo = c_done - nbit * p;
    if (c_start < lo || c_start > lo + bd) begin
      n_bad++;
      $display("FAIL %s_start_pos: start at clk %0d want %0d..%0d (par=%0b)", name, c_start, lo, lo + bd, par);
    end

    for (int j = 0; j < nbit; j++) begin
      s = (j == 0) ? c_start : c_done - (nbit - j) * p;
      e = c_done - (nbit - 1 - j) * p;
      ok = (s >= 0);
      got = exp_bits[j];
      for (int c = (s < 0 ? 0 : s); c < e; c++)
        if (ok && samp[c] !== exp_bits[j]) begin ok = 1'b0; got = samp[c]; end
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s_bit%0d: got tx=%b want %b", name, j, got, exp_bits[j]);
      end
    end

    if (!early_release) begin
      ok = 1'b1;
      for (int c = 0; c < 2 * p; c++) begin
        @(negedge clk);
        if (tx !== 1'b1 || bus.tx_done !== 1'b1) ok = 1'b0;
      end
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL %s_hold: got tx/done change while tx_en high, want tx=1 done=1", name); end
      bus.tx_en = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.tx_done !== 1'b0 || tx !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_release: got done=%b tx=%b want done=0 tx=1", name, bus.tx_done, tx);
    end
  endtask

  task automatic test_basic();
    set_baud(3);
    run_frame(8'hA5, 4'd8, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_handshake();
    run_frame(8'h0A, 4'd8, 1'b0, 1'b0, "handshake");
  endtask

  task automatic test_nbits();
    run_frame(8'hFF, 4'd5,  1'b0, 1'b0, "nbits5");
    run_frame(8'h3C, 4'd12, 1'b0, 1'b0, "nbits12");
    run_frame(8'h5A, 4'd2,  1'b0, 1'b0, "nbits2");
  endtask

  task automatic test_early_release();
    run_frame(8'hC3, 4'd7, 1'b0, 1'b1, "early");
  endtask

  task automatic test_mid_reset();
    logic ok;
    set_baud(3);
    bus.tx_data = 8'hA5;
    bus.nbits   = 4'd8;
    bus.tx_en   = 1'b1;
    repeat (280) @(negedge clk);
    reset     = 1'b1;
    bus.tx_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1)          begin n_bad++; $display("FAIL midrst_tx: got %b want 1", tx); end
    n_cmp++; if (bus.tx_done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", bus.tx_done); end
    reset = 1'b0;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.tx_done !== 1'b0) ok = 1'b0;
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL midrst_idle: got activity with tx_en low, want tx=1 done=0"); end
    run_frame(8'h96, 4'd8, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      set_baud(int'($urandom_range(0, 3)));
      run_frame(8'($urandom), 4'($urandom), 1'($urandom), 1'b0, $sformatf("rand%0d", k));
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    set_baud(3);
    run_frame(8'hA5, 4'd8, 1'b0, 1'b0, "parity_even");
    run_frame(8'hA5, 4'd8, 1'b1, 1'b0, "parity_odd");
  endtask
`endif

  initial begin
    test_reset();
    test_tick(3);
    test_tick(0);
    test_tick(1);
    test_basic();
    test_handshake();
    test_nbits();
    test_early_release();
    test_mid_reset();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_baud.md
Name: uart_tx_baud

Overview:
- Serial transmit block: programmable 16x-oversampling baud tick generator plus an 8N1-style UART transmitter.
- Data width is 5..8 bits, sent LSB first.
- Feeds the design's debug/result UART output pin.
- Byte-level handshake: tx_en request / tx_done completion, so a controller can stream a string one character at a time.

Parameters:
- DIV_W, 16, width of baud divisor and tick counter.
- OVS, 16, ticks per serial bit (oversampling factor); fixed power of two, 16 in this design.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- baud_div  in  DIV_W  tick period minus one, in clk cycles (325 for 50 MHz / 9600 baud).
- tick  out  1  one-clk pulse every baud_div+1 cycles.
- nbits  in  4  data bits per frame; clamped to 5..8 (values <5 use 5, values >8 use 8).
- tx_en  in  1  transmit request, level-sensitive.
- tx_data  in  8  byte to send; only the low nbits are used.
- tx_done  out  1  frame complete; held until tx_en is seen low.
- tx  out  1  serial line, idle high.

Behaviour:
- Reset: tick=0, tx=1, tx_done=0, divider counter=0, FSM=IDLE, all counters cleared.
  - Reset mid-frame aborts the frame; tx=1 on the next cycle.
- Baud generator:
  - Counter increments each clk.
  - When counter==baud_div: tick=1 for that cycle and counter wraps to 0; otherwise tick=0.
  - baud_div=0 gives tick every cycle.
  - A change of baud_div takes effect on the next compare, with no glitch reset.
- All outputs are registered.
- FSM states: IDLE, START, DATA, STOP, DONE.
- IDLE:
  - tx=1.
  - If tx_en=1 and tx_done=0: latch tx_data and the clamped nbits, and go to START.
- START:
  - tx=0; count ticks.
  - After OVS ticks, go to DATA with bit index 0.
  - First bit may be shortened by up to one tick period, because acceptance is not tick-aligned.
- DATA:
  - tx = latched data[bit index]; each bit lasts OVS ticks.
  - After bit nbits-1, go to STOP.
- STOP: tx=1 for OVS ticks, then go to DONE and set tx_done=1 on the same edge.
- DONE:
  - tx=1; tx_done stays 1 while tx_en=1, so holding tx_en does not retransmit.
  - When tx_en=0 is sampled: tx_done=0 next cycle, FSM to IDLE.
- Frame length: (nbits+2)*OVS ticks.
- tx_data/nbits changes during a frame are ignored (latched copy used).
- tx_en deassertion mid-frame does not abort; the frame completes.
  - DONE then exits on the first low sample, so tx_done is high for one cycle.
- Tick counter in the bit states counts ticks only; it resets to 0 on each bit boundary.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - Extra input parity_odd (1 bit), latched with data.
  - A PARITY state between DATA and STOP, lasting OVS ticks.
  - tx = XOR of the nbits data bits, XOR parity_odd (even parity when 0).
  - Frame length becomes (nbits+3)*OVS ticks.
- Undefined: no parity_odd port, no PARITY state, behaviour exactly as above.

Test Plan:
- Tick period: baud_div=3 -> tick high exactly 1 of every 4 clks; baud_div=0 -> tick every clk.
- Basic frame: baud_div=3, nbits=8, tx_data=0xA5, tx_en=1 held.
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 clks (start bit up to 4 clks shorter).
  - tx_done rises after the stop bit.
  - No second frame while tx_en stays high.
- Handshake: after tx_done=1 drop tx_en -> tx_done=0 next cycle; re-raise tx_en with 0x0A -> new frame with bits 0,0,1,0,1,0,0,0,0,1.
- nbits=5, tx_data=0xFF -> frame 0,1,1,1,1,1,1 (7 bits, 7*16 ticks); nbits=12 behaves as 8; nbits=2 behaves as 5.
- Reset at data bit 3 -> next cycle tx=1, tx_done=0, FSM IDLE; a fresh tx_en then sends a complete frame.
- With UART_TX_PARITY_EN: 0xA5, parity_odd=0 -> parity bit 0; parity_odd=1 -> parity bit 1; 11-bit frame.
